// File: rtl/mult_pkg.sv
// Shared constants and tree-sizing helpers for the pipelined Wallace multiplier.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MULT_LATENCY  = 3;

  // Rows entering reduction level 'level': WIDTH partial-product rows plus one correction row.
  function automatic int tree_rows(input int width, input int level);
    int rows;
    rows = width + 1;
    for (int l = 0; l < level; l++) begin
      if (rows > 2) rows = 2 * (rows / 3) + (rows % 3);
    end
    return rows;
  endfunction

  function automatic int wallace_levels(input int width);
    int rows;
    int lv;
    rows = width + 1;
    lv   = 0;
    while (rows > 2) begin
      rows = 2 * (rows / 3) + (rows % 3);
      lv++;
    end
    return lv;
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// Row of 3:2 compressors; the carry row comes out already weighted (shifted left by one).
module csa_3to2 #(
  parameter int BITS = 16
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic [BITS-1:0] c,
  output logic [BITS-1:0] sum,
  output logic [BITS-1:0] carry
);

  assign sum = a ^ b ^ c;

  // The carry out of the top bit falls outside the product width and is dropped.
  assign carry = {((a[BITS-2:0] & b[BITS-2:0]) |
                   (a[BITS-2:0] & c[BITS-2:0]) |
                   (b[BITS-2:0] & c[BITS-2:0])), 1'b0};

endmodule

// File: rtl/wallace_mult_pipe.sv
// Three-stage signed/unsigned multiplier: operand regs, Baugh-Wooley Wallace tree, final add.
module wallace_mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   n,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW     = 2 * WIDTH;
  localparam int ROWS   = WIDTH + 1;
  localparam int LEVELS = wallace_levels(WIDTH);

  logic             stall;
  logic             v1;
  logic             v2;
  logic [WIDTH-1:0] m1;
  logic [WIDTH-1:0] n1;
  logic             sg1;
  logic [PW-1:0]    sum2;
  logic [PW-1:0]    cry2;

  logic [PW-1:0] pp_rows [ROWS];
  logic [PW-1:0] tree [LEVELS+1][ROWS];

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Baugh-Wooley: in signed mode the MSB row and MSB column are inverted (corner bit kept),
  // and the extra row adds 2^WIDTH + 2^(2*WIDTH-1).
  always_comb begin
    for (int i = 0; i < ROWS; i++) pp_rows[i] = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_rows[i][i+j] = (m1[j] & n1[i]) ^ (sg1 & ((i == WIDTH-1) != (j == WIDTH-1)));
      end
    end
    if (sg1) begin
      pp_rows[WIDTH][WIDTH]  = 1'b1;
      pp_rows[WIDTH][PW-1]   = 1'b1;
    end
  end

  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_l0
      assign tree[0][r] = pp_rows[r];
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int R  = tree_rows(WIDTH, l);
      localparam int G  = R / 3;
      localparam int RN = 2 * G + (R % 3);

      for (genvar g = 0; g < G; g++) begin : g_csa
        csa_3to2 #(.BITS(PW)) u_csa (
          .a     (tree[l][3*g]),
          .b     (tree[l][3*g+1]),
          .c     (tree[l][3*g+2]),
          .sum   (tree[l+1][2*g]),
          .carry (tree[l+1][2*g+1])
        );
      end

      for (genvar k = 0; k < (R % 3); k++) begin : g_pass
        assign tree[l+1][2*G+k] = tree[l][3*G+k];
      end

      for (genvar z = RN; z < ROWS; z++) begin : g_zero
        assign tree[l+1][z] = '0;
      end
    end
  endgenerate

  // Every stage advances together; a stall freezes the whole pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      m1        <= '0;
      n1        <= '0;
      sg1       <= 1'b0;
      v2        <= 1'b0;
      sum2      <= '0;
      cry2      <= '0;
      out_valid <= 1'b0;
      p         <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      if (in_valid) begin
        m1  <= m;
        n1  <= n;
        sg1 <= SIGNED_EN ? is_signed : 1'b0;
      end
      v2 <= v1;
      if (v1) begin
        sum2 <= tree[LEVELS][0];
        cry2 <= tree[LEVELS][1];
      end
      out_valid <= v2;
      if (v2) p <= sum2 + cry2;
    end
  end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Directed and randomized checks of wallace_mult_pipe against an arithmetic product model.
module tb_wallace_mult_pipe;
  import mult_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic sweep_go;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Product of two w-bit operands, interpreted per mode, reduced modulo 2^(2w).
  function automatic logic [63:0] ref_prod(input int w, input bit sg,
                                           input logic [63:0] a, input logic [63:0] b);
    longint      sa, sb;
    logic [63:0] mask_w, r;
    mask_w = (64'd1 << w) - 64'd1;
    a = a & mask_w;
    b = b & mask_w;
    if (sg) begin
      sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
      r  = 64'(sa * sb);
    end else begin
      r = a * b;
    end
    if (2 * w < 64) r = r & ((64'd1 << (2 * w)) - 64'd1);
    return r;
  endfunction

  // Directed instance: WIDTH=8, signed mode enabled.
  logic        d_in_valid, d_in_ready, d_sg, d_out_valid, d_out_ready;
  logic [7:0]  d_m, d_n;
  logic [15:0] d_p;

  wallace_mult_pipe #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .m         (d_m),
    .n         (d_n),
    .is_signed (d_sg),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .p         (d_p)
  );

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic s);
    d_in_valid = v;
    d_m        = a;
    d_n        = b;
    d_sg       = s;
  endtask

  task automatic run_one(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic [15:0] exp);
    int k;
    @(negedge clk);
    d_out_ready = 1'b1;
    drive(1'b1, a, b, s);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    k = 0;
    #1;
    while (!d_out_valid && k < 10) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!d_out_valid) check_val({tag, "_timeout"}, 64'd0, 64'd1);
    else check_val(tag, 64'(d_p), 64'(exp));
  endtask

  // Random sweep instances, one per WIDTH/SIGNED_EN combination.
  for (genvar c = 0; c < 6; c++) begin : g_sw
    localparam int W  = (c < 2) ? 4 : ((c < 4) ? 16 : 32);
    localparam bit SE = (c % 2) == 1;

    logic           iv, ir, sg, ov, ordy, done;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] pp;

    wallace_mult_pipe #(.WIDTH(W), .SIGNED_EN(SE)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv),
      .in_ready  (ir),
      .m         (a),
      .n         (b),
      .is_signed (sg),
      .out_valid (ov),
      .out_ready (ordy),
      .p         (pp)
    );

    initial begin
      logic [63:0] exp_q[$];
      logic [63:0] e;
      int          sent, got;
      logic        acc;
      iv = 1'b0; a = '0; b = '0; sg = 1'b0; ordy = 1'b0; done = 1'b0;
      sent = 0; got = 0; acc = 1'b0;
      wait (sweep_go);
      for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
        @(negedge clk);
        if (acc) iv = 1'b0;
        if (!iv && sent < 1000 && $urandom_range(3) != 0) begin
          iv = 1'b1;
          a  = W'($urandom);
          b  = W'($urandom);
          if ($urandom_range(7) == 0) a = {1'b1, {(W-1){1'b0}}};
          if ($urandom_range(7) == 0) b = {1'b1, {(W-1){1'b0}}};
          if ($urandom_range(7) == 0) a = '1;
          sg = 1'($urandom_range(1));
        end
        ordy = 1'($urandom_range(1));
        #1;
        acc = iv && ir;
        if (acc) begin
          exp_q.push_back(ref_prod(W, SE && sg, 64'(a), 64'(b)));
          sent++;
        end
        if (ov && ordy) begin
          if (exp_q.size() == 0) begin
            check_val($sformatf("sweep_w%0d_s%0d_extra", W, SE), 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check_val($sformatf("sweep_w%0d_s%0d", W, SE), 64'(pp), e);
          end
          got++;
        end
      end
      if (got < 1000) check_val($sformatf("sweep_w%0d_s%0d_count", W, SE), 64'(got), 64'd1000);
      done = 1'b1;
    end
  end

  initial begin
    logic [15:0] q[$];
    logic [15:0] bp_exp [4];
    int          seen;
    int          t;
    rst = 1'b1;
    sweep_go = 1'b0;
    d_out_ready = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 1'b0);

    #22;
    check_val("rst_out_valid", 64'(d_out_valid), 64'd0);
    check_val("rst_p", 64'(d_p), 64'd0);
    check_val("rst_in_ready", 64'(d_in_ready), 64'd1);

    // Back-to-back stream, first drive right as reset releases.
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'd10, 8'd10, 1'b0);
    #1 check_val("ready_after_rst", 64'(d_in_ready), 64'd1);
    @(negedge clk);
    drive(1'b1, 8'd50, 8'd20, 1'b0);
    #1 check_val("lat_c1_valid", 64'(d_out_valid), 64'd0);
    @(negedge clk);
    drive(1'b1, 8'd8, 8'd6, 1'b0);
    #1 check_val("lat_c2_valid", 64'(d_out_valid), 64'd0);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    #1 check_val("lat_c3_valid", 64'(d_out_valid), 64'd1);
    check_val("stream_p0", 64'(d_p), 64'd100);
    @(negedge clk);
    #1 check_val("stream_v1", 64'(d_out_valid), 64'd1);
    check_val("stream_p1", 64'(d_p), 64'd1000);
    @(negedge clk);
    #1 check_val("stream_v2", 64'(d_out_valid), 64'd1);
    check_val("stream_p2", 64'(d_p), 64'd48);
    @(negedge clk);
    #1 check_val("bubble_valid", 64'(d_out_valid), 64'd0);
    check_val("bubble_p_hold", 64'(d_p), 64'd48);

    run_one("u_255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run_one("s_m3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1);
    run_one("s_min_x_min", 8'h80, 8'h80, 1'b1, 16'h4000);
    run_one("u_128x128", 8'h80, 8'h80, 1'b0, 16'h4000);
    run_one("s_m1xm1", 8'hFF, 8'hFF, 1'b1, 16'h0001);
    run_one("s_min_x_max", 8'h80, 8'h7F, 1'b1, 16'hC080);

    // Backpressure: three in flight, stall five cycles while a fourth waits at the input.
    @(negedge clk);
    d_out_ready = 1'b1;
    drive(1'b1, 8'd18, 8'd18, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'd22, 8'd24, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'd7, 8'd9, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'd11, 8'd11, 1'b0);
    d_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      check_val($sformatf("bp_in_ready_%0d", k), 64'(d_in_ready), 64'd0);
      check_val($sformatf("bp_valid_%0d", k), 64'(d_out_valid), 64'd1);
      check_val($sformatf("bp_p_hold_%0d", k), 64'(d_p), 64'd324);
    end
    @(negedge clk);
    d_out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (d_out_valid && d_out_ready) q.push_back(d_p);
      @(negedge clk);
      if (k == 0) drive(1'b0, 8'd0, 8'd0, 1'b0);
    end
    bp_exp[0] = 16'd324; bp_exp[1] = 16'd528; bp_exp[2] = 16'd63; bp_exp[3] = 16'd121;
    check_val("bp_count", 64'(q.size()), 64'd4);
    for (int i = 0; i < 4 && i < q.size(); i++)
      check_val($sformatf("bp_order_%0d", i), 64'(q[i]), 64'(bp_exp[i]));

    // Reset with two products in flight, the first already presented but not taken.
    d_out_ready = 1'b0;
    drive(1'b1, 8'd100, 8'd2, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'd7, 8'd7, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    @(negedge clk);
    #1 check_val("pre_rst_valid", 64'(d_out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check_val("midrst_out_valid", 64'(d_out_valid), 64'd0);
    check_val("midrst_p", 64'(d_p), 64'd0);
    check_val("midrst_in_ready", 64'(d_in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    d_out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (d_out_valid) seen++;
      @(negedge clk);
    end
    check_val("rst_no_emit", 64'(seen), 64'd0);
    run_one("after_rst_3x4", 8'd3, 8'd4, 1'b0, 16'd12);

    sweep_go = 1'b1;
    t = 0;
    while (t < 40000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done &&
                          g_sw[3].done && g_sw[4].done && g_sw[5].done)) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40000) check_val("sweep_timeout", 64'd0, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
